// File: rtl/nlprg_14_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nlprg_14_pkg
// Description : Shared width, feedback taps and reset value for the 14-bit
//               nonlinear pseudo-random generator.
// Revision    : 1.0 - initial release
// ============================================================================
package nlprg_14_pkg;

  localparam int NLPRG14_W = 14;

  typedef logic [NLPRG14_W-1:0] nlprg_word_t;

  // Taps 14,13,12,2 of a primitive polynomial, as 0-based bit indices
  localparam int TAP_0 = 13;
  localparam int TAP_1 = 12;
  localparam int TAP_2 = 11;
  localparam int TAP_3 = 1;

  localparam nlprg_word_t RESET_VAL = 14'h0000;

endpackage : nlprg_14_pkg
`default_nettype wire

// File: rtl/nlprg_14_if.sv
`default_nettype none
// ============================================================================
// Module      : nlprg_14_if
// Description : Output bus of the 14-bit generator; master drives, slave reads.
// Revision    : 1.0 - initial release
// ============================================================================
interface nlprg_14_if;
  import nlprg_14_pkg::*;

  nlprg_word_t o;

  modport master (output o);
  modport slave  (input  o);

endinterface : nlprg_14_if
`default_nettype wire

// File: rtl/nlprg_14.sv
`default_nettype none
// ============================================================================
// Module      : nlprg_14
// Description : Free-running 14-bit LFSR with de Bruijn zero insertion,
//               giving a full 16384-state cycle that includes all-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module nlprg_14
  import nlprg_14_pkg::*;
(
  input  wire logic   ck,
  input  wire logic   rst,
  nlprg_14_if.master  bus
);

  localparam int N = NLPRG14_W;

  nlprg_word_t state;
  logic        fb;

  // The zero-detect term looks only at the low 13 bits so that it fires on
  // both 14'h2000 (diverting it to 0) and 14'h0000 (escaping the lockup).
  function automatic logic next_bit(input nlprg_word_t s);
    logic lin;
    logic z;
    lin = s[TAP_0] ^ s[TAP_1] ^ s[TAP_2] ^ s[TAP_3];
    z   = (s[N-2:0] == '0);
    return lin ^ z;
  endfunction

  always_comb begin
    fb = next_bit(state);
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state <= RESET_VAL;
    end else begin
      state <= {state[N-2:0], fb};
    end
  end

  assign bus.o = state;

endmodule : nlprg_14
`default_nettype wire

// File: tb/tb_nlprg_14.sv
`default_nettype none
// ============================================================================
// Module      : tb_nlprg_14
// Description : Directed self-checking bench for the 14-bit generator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nlprg_14;

  logic ck;
  logic rst;

  int checks   = 0;
  int failures = 0;

  nlprg_14_if bus ();

  nlprg_14 dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  logic [13:0] rec  [16384];
  bit          seen [16384];
  logic [13:0] startup [6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int first_zero;
    int dups;
    int mism;
    int zeros_early;

    startup[0] = 14'd1;
    startup[1] = 14'd2;
    startup[2] = 14'd5;
    startup[3] = 14'd10;
    startup[4] = 14'd21;
    startup[5] = 14'd42;

    // Reset hold with the clock running
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge ck);
      #1;
      check($sformatf("reset_hold_%0d", i), 32'(bus.o), 32'h0);
    end

    @(negedge ck);
    rst = 1'b1;
    #1;
    check("after_release_before_edge", 32'(bus.o), 32'h0);
    rec[0] = bus.o;

    // First period: startup values, first return to zero at 16384
    first_zero  = -1;
    zeros_early = 0;
    for (int k = 1; k <= 16384; k++) begin
      @(posedge ck);
      #1;
      if (k <= 6)
        check($sformatf("startup_%0d", k), 32'(bus.o), 32'(startup[k-1]));
      if (k < 16384) begin
        rec[k] = bus.o;
        if (bus.o == 14'h0) zeros_early++;
      end
      if (bus.o == 14'h0 && first_zero < 0) first_zero = k;
    end
    check("first_zero_cycle", 32'(first_zero), 32'd16384);
    check("zeros_before_wrap", 32'(zeros_early), 32'd0);
    check("value_before_zero", 32'(rec[16383]), 32'h2000);

    dups = 0;
    for (int k = 0; k < 16384; k++) begin
      if (seen[rec[k]]) dups++;
      seen[rec[k]] = 1'b1;
    end
    check("uniqueness_dups", 32'(dups), 32'd0);

    // Second period: compare against the first, bit-exact
    mism = 0;
    for (int k = 1; k < 16384; k++) begin
      @(posedge ck);
      #1;
      if (bus.o !== rec[k]) mism++;
      if (k == 16383)
        check("second_period_pre_zero", 32'(bus.o), 32'h2000);
    end
    @(posedge ck);
    #1;
    check("second_period_zero", 32'(bus.o), 32'h0);
    check("second_period_match", 32'(mism), 32'd0);

    // Mid-run asynchronous reset between edges
    repeat (777) @(posedge ck);
    #3;
    check("pre_midrun_reset_nonzero", 32'(bus.o != 14'h0), 32'd1);
    rst = 1'b0;
    #1;
    check("midrun_async_reset", 32'(bus.o), 32'h0);
    @(posedge ck);
    #1;
    check("midrun_reset_hold", 32'(bus.o), 32'h0);
    @(negedge ck);
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge ck);
      #1;
      check($sformatf("restart_%0d", k), 32'(bus.o), 32'(startup[k-1]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_nlprg_14
`default_nettype wire
